demux14_serializer: RTL
=======================

# demux14_serializer

Upstream feeder for the 1:4 demultiplexer. Accepts parallel words tagged with a 2-bit channel number over a valid/ready handshake and shifts each word out LSB-first as a serial bit stream. Drives the demux select lines `sel` and data line `dout`, so each word lands bit-by-bit on the addressed demux output. Words to disabled channels are dropped and counted.

## Interface
- `WIDTH`, default 8: payload bits per word; legal range 2–16.
- `GAP`, default 1: idle cycles inserted after each frame; legal range 0–15.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_chan`  in  2  destination channel 0–3.
- `in_data`  in  WIDTH  payload.
- `ch_en`  in  4  per-channel enable mask; bit n enables channel n.
- `sel`  out  2  demux select (the demux `A` input).
- `dout`  out  1  serial data (the demux `din` input).
- `dout_valid`  out  1  `dout` carries a payload bit.
- `frame_start`  out  1  pulse on the first bit of a frame.
- `frame_end`  out  1  pulse on the last bit of a frame.
- `drop_cnt`  out  8  count of dropped words, saturating.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE: `in_ready`=1. Handshake completes when `in_valid`&&`in_ready` at a rising edge.
  - If `ch_en[in_chan]`=1: latch `in_data` into the shift register and `in_chan` into `sel`, clear the bit counter, go to SHIFT.
  - If `ch_en[in_chan]`=0: drop the word. `drop_cnt` increments and holds at 255. Stay in IDLE; `sel` is unchanged.
- SHIFT: `in_ready`=0, `dout_valid`=1, `dout` = shift-register bit 0. Shift right each cycle. The bit counter runs 0..WIDTH-1.
  - `frame_start`=1 when count=0. `frame_end`=1 when count=WIDTH-1 (both are 1 in the same cycle only if WIDTH=1, which is illegal).
  - After the bit at WIDTH-1: go to GAP if GAP>0, otherwise to IDLE.
- GAP: `in_ready`=0, `dout_valid`=0. Count GAP cycles, then go to IDLE.
- `dout` is forced to 0 whenever `dout_valid`=0, so every demux output stays low between frames.
- `sel` holds its value from the last accepted frame until the next accept.
- `ch_en` is sampled only at accept. Changing it mid-frame does not affect the frame in flight.
- `in_data` and `in_chan` are don't-care unless a handshake completes.

## Timing
- Reset values (`rst_n`=0 at an edge): state IDLE, `in_ready`=1, `sel`=0, `dout`=0, `dout_valid`=0, `frame_start`=0, `frame_end`=0, `drop_cnt`=0, all counters 0.
- Reset mid-frame or mid-GAP aborts immediately. No partial bits appear after reset is released.
- `in_ready` is registered state decode and does not depend combinationally on `in_valid`.
- Latency: if a word is accepted at edge k, bit 0 is on `dout` in cycle k+1 and bit WIDTH-1 in cycle k+WIDTH.
- First IDLE cycle after a frame is k+WIDTH+GAP+1. Sustained throughput is one word per WIDTH+GAP+1 cycles.
- A drop occupies one IDLE cycle. Back-to-back drops count once per cycle.
- `sel` changes only on the edge that starts SHIFT, so it is stable for the whole frame.

## Structure
- Shared package `demux_pkg`:
  - state enum {IDLE, SHIFT, GAP};
  - `CHAN_W`=2, `NUM_CHAN`=4, `DROP_W`=8.
- One sub-module is natural: `sat_counter` (parameterised width, increment enable, saturate at all-ones, sync active-low clear), used for `drop_cnt`.
- Integration check: the block's `sel`/`dout` feed the demux `A`/`din` directly. The top-level bench checks the combined pair.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles -> all outputs at reset values, `in_ready`=1, demux outputs Y=0000.
- Single word, `ch_en`=1111, `in_chan`=2, `in_data`=8'hA5, WIDTH=8, GAP=1, accepted at edge k:
  - cycles k+1..k+8 show `dout`=1,0,1,0,0,1,0,1 with `sel`=2;
  - `frame_start` at k+1, `frame_end` at k+8;
  - `in_ready` returns at k+10.
- Drop path, `ch_en`=1011, `in_chan`=2 on 3 consecutive cycles -> `drop_cnt`=3, `dout_valid` stays 0, `sel` unchanged.
- Saturation: 300 drops -> `drop_cnt`=255 and holds.
- Back-to-back words to channels 0,1,3 with `in_valid` held high, GAP=0 -> frames are contiguous (period 9 cycles), each with the correct `sel`. Demux outputs show bits only on Y[0], Y[1], Y[3] in turn.
- Reset asserted at bit 4 of a frame -> on the next edge all outputs are at reset values. A new word accepted after release serialises from bit 0.

Source files
------------

// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Brief  : Shared types and constants for the 1:4 demux serializer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int CHAN_W   = 2;
    localparam int NUM_CHAN = 4;
    localparam int DROP_W   = 8;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/demux14_serializer_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; synchronous active-low clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/demux14_serializer.sv
// ============================================================================
// Module : demux14_serializer
// Brief  : Serialises channel-tagged words LSB-first onto demux sel/din lines.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux14_serializer
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHAN_W-1:0]    in_chan,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [NUM_CHAN-1:0]  ch_en,
    output logic [CHAN_W-1:0]    sel,
    output logic                 dout,
    output logic                 dout_valid,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam logic [CNT_W-1:0] c_width_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

    state_e              r_state;
    logic [WIDTH-1:0]    r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic [CHAN_W-1:0]   r_sel;

    logic w_idle;
    logic w_take;
    logic w_accept;
    logic w_drop;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_take   = w_idle & in_valid;
    assign w_accept = w_take & ch_en[in_chan];
    assign w_drop   = w_take & ~ch_en[in_chan];

    // r_cnt is shared: it indexes the payload bit in SHIFT and the idle slot in GAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift <= in_data;
                        r_sel   <= in_chan;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= r_shift >> 1;
                    if (r_cnt == c_width_last) begin
                        r_cnt   <= '0;
                        r_state <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_drop),
        .count (drop_cnt)
    );

    // Outputs decode registered state only, so dout is low outside a frame.
    assign in_ready    = w_idle;
    assign dout_valid  = (r_state == ST_SHIFT);
    assign dout        = dout_valid & r_shift[0];
    assign frame_start = dout_valid & (r_cnt == '0);
    assign frame_end   = dout_valid & (r_cnt == c_width_last);
    assign sel         = r_sel;

endmodule

`default_nettype wire
